// File: rtl/ff_conv_pkg.sv
// ============================================================================
//  Module      : ff_conv_pkg
//  Description : Opcode and FSM state encodings shared by the SR-bank
//                conversion controller, plus a small classification helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ff_conv_pkg;

    typedef logic [2:0] op_t;
    typedef logic [1:0] state_t;

    localparam op_t c_OP_NOP    = 3'b000;
    localparam op_t c_OP_SET    = 3'b001;
    localparam op_t c_OP_CLR    = 3'b010;
    localparam op_t c_OP_TOGGLE = 3'b011;
    localparam op_t c_OP_LOAD   = 3'b100;
    localparam op_t c_OP_JK     = 3'b101;
    localparam op_t c_OP_COUNT  = 3'b110;
    localparam op_t c_OP_ILL    = 3'b111;

    localparam state_t c_ST_IDLE   = 2'd0;
    localparam state_t c_ST_APPLY  = 2'd1;
    localparam state_t c_ST_SETTLE = 2'd2;
    localparam state_t c_ST_DONE   = 2'd3;

    // Commands that never touch the bank: NOP, illegal, and a zero-step COUNT.
    function automatic logic f_no_apply(input op_t op, input logic data_zero);
        return (op == c_OP_NOP) || (op == c_OP_ILL) ||
               ((op == c_OP_COUNT) && data_zero);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ff_conv_ctrl_if.sv
// ============================================================================
//  Module      : ff_conv_ctrl_if
//  Description : Valid/ready command channel into the SR-bank controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ff_conv_ctrl_if
    import ff_conv_pkg::*;
#(
    parameter int W = 4
);
    logic         cmd_valid;
    logic         cmd_ready;
    op_t          cmd_op;
    logic [W-1:0] cmd_mask;
    logic [W-1:0] cmd_data;
    logic [W-1:0] cmd_k;

    modport master (
        output cmd_valid, cmd_op, cmd_mask, cmd_data, cmd_k,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_mask, cmd_data, cmd_k,
        output cmd_ready
    );

endinterface

`default_nettype wire

// File: rtl/ff_excite.sv
// ============================================================================
//  Module      : ff_excite
//  Description : Combinational set/reset excitation for a W-bit SR bank,
//                derived from opcode, mask, operand vectors and present q.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ff_excite
    import ff_conv_pkg::*;
#(
    parameter int W = 4
) (
    input  op_t          op,
    input  logic [W-1:0] mask,
    input  logic [W-1:0] vec,
    input  logic [W-1:0] k,
    input  logic [W-1:0] q,
    output logic [W-1:0] s,
    output logic [W-1:0] r
);

    // Binary-increment toggle vector: bit i flips when all lower bits are 1.
    logic [W-1:0] w_cnt_t;

    assign w_cnt_t[0] = 1'b1;

    generate
        for (genvar i = 1; i < W; i++) begin : g_carry
            assign w_cnt_t[i] = w_cnt_t[i-1] & q[i-1];
        end
    endgenerate

    // Every term that can raise both s and r is split on q / ~q, so s & r is 0.
    always_comb begin
        s = '0;
        r = '0;
        case (op)
            c_OP_SET: begin
                s = mask;
            end
            c_OP_CLR: begin
                r = mask;
            end
            c_OP_TOGGLE: begin
                s = mask & vec & ~q;
                r = mask & vec & q;
            end
            c_OP_LOAD: begin
                s = mask & vec & ~q;
                r = mask & ~vec & q;
            end
            c_OP_JK: begin
                s = mask & vec & ~q;
                r = mask & k & q;
            end
            c_OP_COUNT: begin
                s = w_cnt_t & ~q;
                r = w_cnt_t & q;
            end
            default: begin
                s = '0;
                r = '0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ff_conv_ctrl.sv
// ============================================================================
//  Module      : ff_conv_ctrl
//  Description : Command FSM driving an external W-bit SR flip-flop bank.
//                Optional macro FF_CONV_CTRL_CHECK_EN adds a settle-time
//                readback check that aborts with err on a mismatch.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ff_conv_ctrl
    import ff_conv_pkg::*;
#(
    parameter int W = 4
) (
    input  logic          clk,
    input  logic          rst,
    ff_conv_ctrl_if.slave cmd,
    input  logic [W-1:0]  q,
    output logic [W-1:0]  s,
    output logic [W-1:0]  r,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_t       r_state;
    state_t       w_next;
    op_t          r_op;
    logic [W-1:0] r_mask;
    logic [W-1:0] r_data;
    logic [W-1:0] r_k;
    logic [W-1:0] r_cnt;
    logic         r_err;
    logic         r_hold;
    logic         w_accept;
    logic [W-1:0] w_cnt_dec;
    logic [W-1:0] w_s;
    logic [W-1:0] w_r;
    logic         w_chk_fail;

`ifdef FF_CONV_CTRL_CHECK_EN
    logic [W-1:0] r_exp;
    assign w_chk_fail = (q != r_exp);
`else
    assign w_chk_fail = 1'b0;
`endif

    assign w_accept      = (r_state == c_ST_IDLE) && cmd.cmd_valid;
    assign w_cnt_dec     = r_cnt - W'(1);
    assign cmd.cmd_ready = (r_state == c_ST_IDLE);
    assign busy          = (r_state != c_ST_IDLE);
    // Zero-work commands spend two cycles in DONE; the pulse is on the second.
    assign done          = (r_state == c_ST_DONE) && !r_hold;
    assign err           = done && r_err;

    ff_excite #(
        .W (W)
    ) u_excite (
        .op   (r_op),
        .mask (r_mask),
        .vec  (r_data),
        .k    (r_k),
        .q    (q),
        .s    (w_s),
        .r    (w_r)
    );

    assign s = (r_state == c_ST_APPLY) ? w_s : '0;
    assign r = (r_state == c_ST_APPLY) ? w_r : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    if (f_no_apply(cmd.cmd_op, cmd.cmd_data == '0)) begin
                        w_next = c_ST_DONE;
                    end else begin
                        w_next = c_ST_APPLY;
                    end
                end
            end
            c_ST_APPLY: begin
                w_next = c_ST_SETTLE;
            end
            c_ST_SETTLE: begin
                if (w_chk_fail) begin
                    w_next = c_ST_DONE;
                end else if ((r_op == c_OP_COUNT) && (w_cnt_dec != '0)) begin
                    w_next = c_ST_APPLY;
                end else begin
                    w_next = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                if (!r_hold) begin
                    w_next = c_ST_IDLE;
                end
            end
            default: begin
                w_next = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op   <= c_OP_NOP;
            r_mask <= '0;
            r_data <= '0;
            r_k    <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
            r_hold <= 1'b0;
`ifdef FF_CONV_CTRL_CHECK_EN
            r_exp  <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_op   <= cmd.cmd_op;
                r_mask <= cmd.cmd_mask;
                r_data <= cmd.cmd_data;
                r_k    <= cmd.cmd_k;
                r_cnt  <= (cmd.cmd_op == c_OP_COUNT) ? cmd.cmd_data : '0;
                r_err  <= (cmd.cmd_op == c_OP_ILL);
                r_hold <= f_no_apply(cmd.cmd_op, cmd.cmd_data == '0);
            end
            if (r_state == c_ST_SETTLE) begin
                if (r_op == c_OP_COUNT) begin
                    r_cnt <= w_cnt_dec;
                end
                if (w_chk_fail) begin
                    r_err <= 1'b1;
                    r_cnt <= '0;
                end
            end
            if (r_state == c_ST_DONE) begin
                r_hold <= 1'b0;
            end
`ifdef FF_CONV_CTRL_CHECK_EN
            if (r_state == c_ST_APPLY) begin
                r_exp <= (q | w_s) & ~w_r;
            end
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ff_conv_ctrl.sv
// ============================================================================
//  Module      : tb_ff_conv_ctrl
//  Description : Directed self-checking bench for ff_conv_ctrl with a
//                behavioural SR bank (FF_CONV_CTRL_CHECK_EN adds a stuck-bit case).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ff_conv_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] q;
    logic [3:0] s;
    logic [3:0] r;
    logic       busy;
    logic       done;
    logic       err;

    ff_conv_ctrl_if #(.W(4)) ifc ();

    ff_conv_ctrl #(.W(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .cmd  (ifc),
        .q    (q),
        .s    (s),
        .r    (r),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    // Behavioural SR bank with a preload port and optional stuck-at-0 bits.
    logic [3:0] bank;
    logic       pre_en;
    logic [3:0] pre_val;
    logic [3:0] stuck;

    assign q = bank & ~stuck;

    always @(posedge clk) begin
        if (pre_en) begin
            bank <= pre_val;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (s[i])      bank[i] <= 1'b1;
                else if (r[i]) bank[i] <= 1'b0;
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [3:0] s_at [0:31];
    logic [3:0] r_at [0:31];
    logic [3:0] q_at [0:31];
    logic       busy_at [0:31];
    int         done_cyc;
    logic       err_done;
    logic       overlap;
    logic       any_sr;

    task automatic preload(input logic [3:0] v);
        pre_val = v;
        pre_en  = 1'b1;
        @(posedge clk); #1;
        pre_en  = 1'b0;
    endtask

    // Issue one command, trace cycles 1.. until done, then step into IDLE.
    task automatic run_cmd(input logic [2:0] op, input logic [3:0] m,
                           input logic [3:0] d, input logic [3:0] k);
        logic acc;
        acc      = 1'b0;
        done_cyc = -1;
        err_done = 1'b0;
        overlap  = 1'b0;
        any_sr   = 1'b0;
        ifc.cmd_op    = op;
        ifc.cmd_mask  = m;
        ifc.cmd_data  = d;
        ifc.cmd_k     = k;
        ifc.cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (ifc.cmd_ready) begin
                @(posedge clk); #1;
                acc = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        ifc.cmd_valid = 1'b0;
        ifc.cmd_op    = ~op;
        ifc.cmd_mask  = ~m;
        ifc.cmd_data  = ~d;
        ifc.cmd_k     = ~k;
        if (!acc) begin
            check("accept_timeout", 1, 0);
            return;
        end
        for (int c = 1; c < 32; c++) begin
            s_at[c]    = s;
            r_at[c]    = r;
            q_at[c]    = q;
            busy_at[c] = busy;
            if ((s & r) != 4'b0) overlap = 1'b1;
            if ((s | r) != 4'b0) any_sr = 1'b1;
            if (done) begin
                done_cyc = c;
                err_done = err;
                break;
            end
            @(posedge clk); #1;
        end
        if (done_cyc < 0) check("done_timeout", 1, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int   ndone;
        logic rdy_busy;
        rst           = 1'b1;
        pre_en        = 1'b0;
        pre_val       = 4'b0;
        stuck         = 4'b0;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_op    = 3'b000;
        ifc.cmd_mask  = 4'b0;
        ifc.cmd_data  = 4'b0;
        ifc.cmd_k     = 4'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        check("rst_ready", ifc.cmd_ready, 1);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_err",   err,  0);
        check("rst_s",     s, 4'b0);
        check("rst_r",     r, 4'b0);

        // SET
        preload(4'b0000);
        run_cmd(3'b001, 4'b1010, 4'b0000, 4'b0000);
        check("set_s_apply", s_at[1], 4'b1010);
        check("set_r_apply", r_at[1], 4'b0000);
        check("set_busy",    busy_at[1], 1);
        check("set_s_settle", s_at[2], 4'b0000);
        check("set_done_cyc", done_cyc, 3);
        check("set_err",     err_done, 0);
        check("set_q",       q, 4'b1010);

        // TOGGLE
        run_cmd(3'b011, 4'b1111, 4'b0110, 4'b0000);
        check("tog_s", s_at[1], 4'b0100);
        check("tog_r", r_at[1], 4'b0010);
        check("tog_q", q, 4'b1100);

        // JK toggle-all
        preload(4'b0011);
        run_cmd(3'b101, 4'b1111, 4'b1111, 4'b1111);
        check("jk_q",       q, 4'b1100);
        check("jk_overlap", overlap, 0);
        check("jk_done_cyc", done_cyc, 3);

        // CLR and LOAD
        preload(4'b1111);
        run_cmd(3'b010, 4'b0110, 4'b0000, 4'b0000);
        check("clr_r", r_at[1], 4'b0110);
        check("clr_q", q, 4'b1001);
        preload(4'b1100);
        run_cmd(3'b100, 4'b1111, 4'b1010, 4'b0000);
        check("load_s", s_at[1], 4'b0010);
        check("load_r", r_at[1], 4'b0100);
        check("load_q", q, 4'b1010);

        // COUNT 3 from 1110 wraps through zero; mask is ignored
        preload(4'b1110);
        run_cmd(3'b110, 4'b0000, 4'd3, 4'b0000);
        check("cnt_s1",      s_at[1], 4'b0001);
        check("cnt_q2",      q_at[2], 4'b1111);
        check("cnt_q4",      q_at[4], 4'b0000);
        check("cnt_q6",      q_at[6], 4'b0001);
        check("cnt_done_cyc", done_cyc, 7);
        check("cnt_overlap", overlap, 0);

        // COUNT 0, NOP, illegal: two-cycle latency, no bank activity
        run_cmd(3'b110, 4'b1111, 4'd0, 4'b0000);
        check("cnt0_done_cyc", done_cyc, 2);
        check("cnt0_any_sr",   any_sr, 0);
        check("cnt0_busy",     busy_at[1], 1);
        run_cmd(3'b000, 4'b1111, 4'b1111, 4'b1111);
        check("nop_done_cyc", done_cyc, 2);
        check("nop_err",      err_done, 0);
        preload(4'b0101);
        run_cmd(3'b111, 4'b1111, 4'b1111, 4'b1111);
        check("ill_done_cyc", done_cyc, 2);
        check("ill_err",      err_done, 1);
        check("ill_any_sr",   any_sr, 0);
        check("ill_q",        q, 4'b0101);

        // Command presented while busy is held off, then executed once
        preload(4'b0000);
        ifc.cmd_op = 3'b001; ifc.cmd_mask = 4'b0001;
        ifc.cmd_data = 4'b0; ifc.cmd_k = 4'b0;
        ifc.cmd_valid = 1'b1;
        @(posedge clk); #1;
        ifc.cmd_op = 3'b010;
        ndone    = 0;
        rdy_busy = 1'b0;
        for (int c = 1; c < 12; c++) begin
            logic take;
            if (busy && ifc.cmd_ready) rdy_busy = 1'b1;
            if (done) ndone++;
            take = ifc.cmd_ready && ifc.cmd_valid;
            @(posedge clk); #1;
            if (take) ifc.cmd_valid = 1'b0;
        end
        ifc.cmd_valid = 1'b0;
        check("hold_ready_busy", rdy_busy, 0);
        check("hold_ndone",      ndone, 2);
        check("hold_q",          q, 4'b0000);

        // Reset during the second COUNT step
        run_cmd(3'b000, 4'b0, 4'b0, 4'b0);
        ifc.cmd_op = 3'b110; ifc.cmd_mask = 4'b0; ifc.cmd_data = 4'd5;
        ifc.cmd_valid = 1'b1;
        @(posedge clk); #1;
        ifc.cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rstmid_s_before", s, 4'b0010);
        #2 rst = 1'b1;
        #1;
        check("rstmid_s",    s, 4'b0000);
        check("rstmid_r",    r, 4'b0000);
        check("rstmid_busy", busy, 0);
        check("rstmid_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rstmid_ready", ifc.cmd_ready, 1);
        check("rstmid_q",     q, 4'b0001);
        run_cmd(3'b001, 4'b1000, 4'b0, 4'b0);
        check("rstmid_next_cyc", done_cyc, 3);
        check("rstmid_next_q",   q, 4'b1001);

`ifdef FF_CONV_CTRL_CHECK_EN
        preload(4'b0000);
        stuck = 4'b0001;
        run_cmd(3'b001, 4'b0001, 4'b0, 4'b0);
        check("chk_done_cyc", done_cyc, 3);
        check("chk_err",      err_done, 1);
        stuck = 4'b0000;
        preload(4'b0000);
        run_cmd(3'b001, 4'b0001, 4'b0, 4'b0);
        check("chk_ok_err", err_done, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
